// File: rtl/risc16_mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | risc16_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer, RisC-16 |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module risc16_mc_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [15:0] ir,
  output logic [2:0]  op,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        halted,
  output logic        error,
  output logic [15:0] retired
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_decode = 3'd2;
  localparam logic [2:0] c_st_exec   = 3'd3;
  localparam logic [2:0] c_st_mem    = 3'd4;
  localparam logic [2:0] c_st_wb     = 3'd5;
  localparam logic [2:0] c_st_halt   = 3'd6;
  localparam logic [2:0] c_st_err    = 3'd7;

  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_addi = 3'b001;
  localparam logic [2:0] c_op_nand = 3'b010;
  localparam logic [2:0] c_op_lui  = 3'b011;
  localparam logic [2:0] c_op_sw   = 3'b100;
  localparam logic [2:0] c_op_lw   = 3'b101;
  localparam logic [2:0] c_op_beq  = 3'b110;
  localparam logic [2:0] c_op_jalr = 3'b111;

  localparam logic [2:0] c_alu_add   = 3'b000;
  localparam logic [2:0] c_alu_nand  = 3'b001;
  localparam logic [2:0] c_alu_lui   = 3'b010;
  localparam logic [2:0] c_alu_pasa  = 3'b011;
  localparam logic [2:0] c_alu_pasb  = 3'b100;

  // Counter value during request cycle k is k-1, so the last legal cycle sees TIMEOUT-1.
  localparam logic [15:0] c_wd_last = 16'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_ir;
  logic [15:0] r_retired;
  logic [15:0] r_wdog;
  logic        w_wd_expire;
  logic        w_is_halt;
  logic        w_in_dp;

  assign op        = r_ir[15:13];
  assign ir        = r_ir;
  assign retired   = r_retired;
  assign w_is_halt = (r_ir[15:13] == c_op_jalr) && (r_ir[6:0] != 7'd0);
  assign w_in_dp   = (r_state == c_st_exec) || (r_state == c_st_mem) || (r_state == c_st_wb);
  assign w_wd_expire = (TIMEOUT != 0) && mem_req && !mem_ack && (r_wdog == c_wd_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:   if (start) w_next = c_st_fetch;
      c_st_fetch: begin
        if (mem_ack)          w_next = c_st_decode;
        else if (w_wd_expire) w_next = c_st_err;
      end
      c_st_decode: w_next = w_is_halt ? c_st_halt : c_st_exec;
      c_st_exec: begin
        case (r_ir[15:13])
          c_op_sw, c_op_lw: w_next = c_st_mem;
          c_op_beq:         w_next = c_st_fetch;
          default:          w_next = c_st_wb;
        endcase
      end
      c_st_mem: begin
        if (mem_ack)          w_next = (r_ir[15:13] == c_op_lw) ? c_st_wb : c_st_fetch;
        else if (w_wd_expire) w_next = c_st_err;
      end
      c_st_wb:     w_next = c_st_fetch;
      c_st_halt:   w_next = c_st_halt;
      c_st_err:    w_next = c_st_err;
      default:     w_next = c_st_idle;
    endcase
  end

  always_comb begin
    mem_req     = (r_state == c_st_fetch) || (r_state == c_st_mem);
    addr_sel    = (r_state == c_st_mem);
    mem_we      = (r_state == c_st_mem) && (r_ir[15:13] == c_op_sw);
    halted      = (r_state == c_st_halt);
    error       = (r_state == c_st_err);
    alu_op      = c_alu_add;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'b00;
    pc_we       = 1'b0;
    if (w_in_dp) begin
      case (r_ir[15:13])
        c_op_nand: alu_op = c_alu_nand;
        c_op_lui:  alu_op = c_alu_lui;
        c_op_beq:  alu_op = c_alu_pasa;
        c_op_jalr: alu_op = c_alu_pasb;
        default:   alu_op = c_alu_add;
      endcase
      alu_src_imm = (r_ir[15:13] == c_op_addi) || (r_ir[15:13] == c_op_lw) ||
                    (r_ir[15:13] == c_op_sw);
    end
    if (r_state == c_st_wb) begin
      reg_we = (r_ir[12:10] != 3'd0);
      pc_we  = 1'b1;
      if (r_ir[15:13] == c_op_lw)        wb_sel = 2'b01;
      else if (r_ir[15:13] == c_op_jalr) wb_sel = 2'b10;
    end
    if ((r_state == c_st_exec) && (r_ir[15:13] == c_op_beq))
      pc_we = 1'b1;
    // sw retires on the edge that completes its memory write.
    if ((r_state == c_st_mem) && (r_ir[15:13] == c_op_sw) && mem_ack)
      pc_we = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_ir      <= 16'h0000;
      r_retired <= 16'h0000;
      r_wdog    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if ((r_state == c_st_fetch) && mem_ack)
        r_ir <= mem_rdata;
      if (pc_we)
        r_retired <= r_retired + 16'd1;
      // Outside a pending request the counter sits at zero, so each FETCH/MEM entry starts fresh.
      if (mem_req && !mem_ack)
        r_wdog <= r_wdog + 16'd1;
      else
        r_wdog <= 16'h0000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc16_mc_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_risc16_mc_ctrl: directed self-checking bench for risc16_mc_ctrl       |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module tb_risc16_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic [15:0] ir;
  logic [2:0]  op;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic        halted;
  logic        error;
  logic [15:0] retired;

  int n_vec = 0;
  int n_err = 0;

  risc16_mc_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir(ir), .op(op),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .halted(halted), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input logic [15:0] d);
    start = s;
    mem_ack = a;
    mem_rdata = d;
    #1;
  endtask

  // Zero-wait fetch of one instruction word; leaves the bench in DECODE with inputs idle.
  task automatic fetch(input logic [15:0] word);
    drive(1'b0, 1'b1, word);
    chk("fetch_req", 32'(mem_req), 32'd1);
    chk("fetch_addr_sel", 32'(addr_sel), 32'd0);
    chk("fetch_we", 32'(mem_we), 32'd0);
    step();
    drive(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    step(); step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    reset = 1'b0;
    step();

    // add r1,r2,r3
    drive(1'b1, 1'b0, 16'h0000);
    chk("idle_req", 32'(mem_req), 32'd0);
    step();
    fetch(16'h0503);
    chk("add_dec_ir", 32'(ir), 32'h0503);
    chk("add_dec_op", 32'(op), 32'd0);
    chk("add_dec_pc_we", 32'(pc_we), 32'd0);
    step();
    chk("add_exec_alu", 32'(alu_op), 32'd0);
    chk("add_exec_pc_we", 32'(pc_we), 32'd0);
    step();
    chk("add_wb_reg_we", 32'(reg_we), 32'd1);
    chk("add_wb_sel", 32'(wb_sel), 32'd0);
    chk("add_wb_pc_we", 32'(pc_we), 32'd1);
    step();
    chk("add_retired", 32'(retired), 32'd1);

    // lw r1,r2,5 with ack on the third MEM cycle
    fetch(16'hA505);
    step();
    chk("lw_exec_alu", 32'(alu_op), 32'd0);
    chk("lw_exec_imm", 32'(alu_src_imm), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i == 2), 16'h1234);
      chk("lw_mem_req", 32'(mem_req), 32'd1);
      chk("lw_mem_addr_sel", 32'(addr_sel), 32'd1);
      chk("lw_mem_we", 32'(mem_we), 32'd0);
      chk("lw_mem_pc_we", 32'(pc_we), 32'd0);
      step();
    end
    drive(1'b0, 1'b0, 16'h0000);
    chk("lw_wb_sel", 32'(wb_sel), 32'd1);
    chk("lw_wb_reg_we", 32'(reg_we), 32'd1);
    chk("lw_wb_pc_we", 32'(pc_we), 32'd1);
    step();
    chk("lw_retired", 32'(retired), 32'd2);

    // addi r0,r1,1: r0 destination suppresses reg_we
    fetch(16'h2081);
    step();
    chk("addi_exec_imm", 32'(alu_src_imm), 32'd1);
    step();
    chk("addi_wb_pc_we", 32'(pc_we), 32'd1);
    chk("addi_wb_reg_we", 32'(reg_we), 32'd0);
    step();
    chk("addi_retired", 32'(retired), 32'd3);

    // beq retires from EXEC
    fetch(16'hC402);
    step();
    chk("beq_exec_alu", 32'(alu_op), 32'd3);
    chk("beq_exec_pc_we", 32'(pc_we), 32'd1);
    chk("beq_exec_reg_we", 32'(reg_we), 32'd0);
    step();
    chk("beq_next_fetch", 32'(mem_req), 32'd1);
    chk("beq_retired", 32'(retired), 32'd4);

    // sw with one wait cycle: pc_we only with the ack
    fetch(16'h8505);
    step();
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_mem_addr_sel", 32'(addr_sel), 32'd1);
    chk("sw_wait_pc_we", 32'(pc_we), 32'd0);
    step();
    drive(1'b0, 1'b1, 16'h0000);
    chk("sw_ack_pc_we", 32'(pc_we), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("sw_next_fetch", 32'(mem_req), 32'd1);
    chk("sw_retired", 32'(retired), 32'd5);

    // jalr r1,r2 (imm 0, not a halt)
    fetch(16'hE500);
    step();
    chk("jalr_exec_alu", 32'(alu_op), 32'd4);
    step();
    chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
    chk("jalr_wb_reg_we", 32'(reg_we), 32'd1);
    chk("jalr_wb_pc_we", 32'(pc_we), 32'd1);
    step();
    chk("jalr_retired", 32'(retired), 32'd6);

    // nand fetched with ack in the 4th (last legal) request cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i == 3), 16'h4503);
      chk("late_ack_req", 32'(mem_req), 32'd1);
      step();
    end
    drive(1'b0, 1'b0, 16'h0000);
    chk("late_ack_error", 32'(error), 32'd0);
    chk("late_ack_ir", 32'(ir), 32'h4503);
    step();
    chk("nand_exec_alu", 32'(alu_op), 32'd1);
    step();
    chk("nand_wb_pc_we", 32'(pc_we), 32'd1);
    step();
    chk("nand_retired", 32'(retired), 32'd7);

    // reset in the middle of a stalled lw MEM phase
    fetch(16'hA505);
    step();
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_retired", 32'(retired), 32'd0);
    chk("rst_mid_ir", 32'(ir), 32'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0000);
    chk("rst_mid_idle", 32'(mem_req), 32'd0);
    step();
    fetch(16'h0503);
    step();
    step();
    step();
    chk("refetch_retired", 32'(retired), 32'd1);

    // halt encoding
    fetch(16'hE071);
    chk("halt_dec_pc_we", 32'(pc_we), 32'd0);
    step();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc_we", 32'(pc_we), 32'd0);
    chk("halt_req", 32'(mem_req), 32'd0);
    drive(1'b1, 1'b0, 16'h0000);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("halt_start_ignored", 32'(halted), 32'd1);
    chk("halt_start_req", 32'(mem_req), 32'd0);
    chk("halt_retired", 32'(retired), 32'd1);
    reset = 1'b1;
    #1;
    chk("halt_reset", 32'(halted), 32'd0);
    step();
    reset = 1'b0;

    // watchdog: no ack in FETCH
    drive(1'b1, 1'b0, 16'h0000);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 16'hFFFF);
      chk("wd_req", 32'(mem_req), 32'd1);
      chk("wd_no_error", 32'(error), 32'd0);
      step();
    end
    drive(1'b0, 1'b0, 16'h0000);
    chk("wd_error", 32'(error), 32'd1);
    chk("wd_req_drop", 32'(mem_req), 32'd0);
    chk("wd_ir_kept", 32'(ir), 32'd0);
    drive(1'b1, 1'b1, 16'h0503);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("wd_error_sticky", 32'(error), 32'd1);
    reset = 1'b1;
    #1;
    chk("wd_reset", 32'(error), 32'd0);
    step();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc16_mc_ctrl.md
# risc16_mc_ctrl

Multi-cycle control sequencer for the RisC-16 core. It fetches each instruction over a single-ported memory request/acknowledge handshake and holds it in an instruction register. It decodes the opcode and steps the datapath (ALU, register file, program counter) through FETCH/DECODE/EXEC/MEM/WB. It also provides halt detection, a memory-stall watchdog and a retired-instruction counter.

## Interface
- TIMEOUT, 16: maximum cycles a memory request may wait for mem_ack; 0 disables the watchdog.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching; ignored in every other state.
- mem_ack  in  1  memory completed the current request this cycle; ignored when mem_req=0.
- mem_rdata  in  16  read data, valid when mem_ack=1.
- mem_req  out  1  memory request active.
- mem_we  out  1  request is a write (sw only).
- addr_sel  out  1  0: address=pc, 1: address=alu_out.
- ir  out  16  instruction register.
- op  out  3  ir[15:13], drives the PC unit opcode input.
- alu_op  out  3  000 ADD, 001 NAND, 010 LUI, 011 PASS_A, 100 PASS_B.
- alu_src_imm  out  1  ALU B operand is the sign-extended imm7 (addi, lw, sw).
- reg_we  out  1  register-file write strobe.
- wb_sel  out  2  00 alu_out, 01 mem_rdata, 10 pc+1.
- pc_we  out  1  PC update strobe, exactly one pulse per retired instruction.
- halted  out  1  in HALT.
- error  out  1  in ERR (watchdog expired).
- retired  out  16  retired-instruction count, wraps 0xFFFF→0x0000.

## Operation
- Opcodes: 000 add, 001 addi, 010 nand, 011 lui, 100 sw, 101 lw, 110 beq, 111 jalr. The halt encoding is op=111 with ir[6:0]≠0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- IDLE: all strobes low. start=1 → FETCH.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. On mem_ack, ir←mem_rdata and the state moves to DECODE.
- DECODE: one cycle. Halt encoding → HALT. Otherwise → EXEC.
- EXEC: one cycle, with alu_op driven from op:
  - ADD for add/addi/lw/sw.
  - NAND for nand.
  - LUI for lui.
  - PASS_A for beq.
  - PASS_B for jalr.
- EXEC next state:
  - add/addi/nand/lui/jalr → WB.
  - lw/sw → MEM.
  - beq: pc_we=1 this cycle, → FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=(op==100). On mem_ack:
  - lw → WB.
  - sw: pc_we=1 in the ack cycle, → FETCH.
- WB: one cycle, pc_we=1, → FETCH.
  - reg_we=1 unless ir[12:10]==0; r0 is never written.
  - wb_sel: 01 for lw, 10 for jalr, 00 otherwise.
- Per-opcode strobes:
  - alu_src_imm is 1 only for addi/lw/sw in EXEC/MEM/WB.
  - alu_op holds its EXEC value through MEM and WB.
  - op always equals ir[15:13].
- HALT: halted=1, all strobes low. Only reset exits.
- ERR: error=1, all strobes low. Only reset exits.
- Watchdog:
  - The counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 without mem_ack.
  - An ack in request cycle k (1-based) is accepted if k≤TIMEOUT.
  - If cycle TIMEOUT ends without an ack → ERR at the next edge, and ir is unchanged.
- retired increments on every cycle with pc_we=1.

## Timing
- Reset (asynchronous) forces immediately:
  - state=IDLE, ir=0x0000, retired=0, watchdog=0.
  - All outputs 0, including a request in flight; mem_req drops without waiting for an ack.
- Strobes are decoded from state and ir. The only Mealy terms are mem_ack-qualified: ir capture, sw pc_we, and the FETCH/MEM exits.
- mem_ack is accepted in the same cycle mem_req rises (zero-wait memory).
- Latency with zero-wait memory, counted from the first FETCH cycle to the pc_we cycle inclusive:
  - beq: 3.
  - add/addi/nand/lui/jalr/sw: 4.
  - lw: 5.
  - Halt: FETCH→DECODE→HALT, 3rd cycle; no pc_we, retired unchanged.
- Each wait cycle on mem_ack adds one cycle per memory access.
- The next FETCH begins the cycle after pc_we; the PC unit has already updated pc at that edge.
- reg_we and pc_we coincide in WB, so the register write and PC update commit on the same edge.

## Test plan
- Reset mid-MEM of lw with mem_req=1 → mem_req=0 combinationally, state IDLE, retired=0; start then refetches from FETCH.
- start, zero-wait memory, program add r1,r2,r3 (0x0503) → FETCH,DECODE,EXEC(alu_op=000),WB(reg_we=1,wb_sel=00,pc_we=1); retired=1 after 4 cycles.
- lw r1,r2,5 (0xA505) with mem_ack delayed 3 cycles in MEM → MEM lasts 3 cycles, addr_sel=1, mem_we=0, then WB with wb_sel=01; total 7 cycles.
- addi r0,r1,1 (0x2081) → WB has pc_we=1, reg_we=0; beq (0xC402) → pc_we in EXEC with alu_op=011, no WB state, 3 cycles.
- TIMEOUT=4, mem_ack never asserted in FETCH → mem_req high 4 cycles, then error=1, mem_req=0, stays until reset; ack in the 4th cycle instead → accepted, DECODE.
- jalr halt encoding 0xE071 → halted=1 on the 3rd cycle, no pc_we, retired unchanged; start pulses ignored; reset clears halted.
